// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
//   Shares one SRAM-like memory port between the instruction cache (I) and
//   the data cache (D). Only one transaction is outstanding at a time. The
//   request fields of the winner are latched at grant. Completion handshakes
//   are routed back only to the recorded owner.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> a simultaneous request goes to the master that did not
//                  complete the previous transaction (last_grant resets to I)
//     undefined -> fixed priority, D beats I
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   i_req/i_wr/i_size/i_addr/i_wdata   I-master request fields
//   i_rdata/i_addr_ok/i_data_ok        I-master returns
//   d_req/d_wr/d_size/d_addr/d_wdata   D-master request fields
//   d_rdata/d_addr_ok/d_data_ok        D-master returns
//   m_req/m_wr/m_size/m_addr/m_wdata   memory-port request (registered)
//   m_rdata/m_addr_ok/m_data_ok        memory-port returns
module cache_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic                  i_wr,
    input  logic [1:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,

    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [1:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,

    output logic                  m_req,
    output logic                  m_wr,
    output logic [1:0]            m_size,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_t;

    state_t state;
    owner_t owner;
    logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = I completed last, 1 = D completed last
    logic last_grant_d;

    // On a conflict the master that did not finish last wins.
    always_comb begin
        pick_d = d_req && (!i_req || !last_grant_d);
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            m_req   <= 1'b0;
            m_wr    <= 1'b0;
            m_size  <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state <= ADDR;
                        m_req <= 1'b1;
                        if (pick_d) begin
                            owner   <= OWN_D;
                            m_wr    <= d_wr;
                            m_size  <= d_size;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            owner   <= OWN_I;
                            m_wr    <= i_wr;
                            m_size  <= i_size;
                            m_addr  <= i_addr;
                            m_wdata <= i_wdata;
                        end
                    end
                end
                ADDR: begin
                    if (m_addr_ok) begin
                        state <= DATA;
                        m_req <= 1'b0;
                    end
                end
                DATA: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                        owner <= OWN_NONE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d <= (owner == OWN_D);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

    // Handshakes are combinational pass-throughs gated by state and owner,
    // so stray memory-port handshakes never reach a master.
    always_comb begin
        i_addr_ok = (state == ADDR) && (owner == OWN_I) && m_addr_ok;
        d_addr_ok = (state == ADDR) && (owner == OWN_D) && m_addr_ok;
        i_data_ok = (state == DATA) && (owner == OWN_I) && m_data_ok;
        d_data_ok = (state == DATA) && (owner == OWN_D) && m_data_ok;
        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed self-checking bench for cache_bus_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled a
// further 1 unit later, well away from the next edge.
module tb_cache_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size, m_size;
    logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_addr_ok(d_addr_ok),
        .d_data_ok(d_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic hs(input string tag, input logic mr, input logic iao, input logic ido,
                      input logic dao, input logic ddo);
        check({tag, ".m_req"},     32'(m_req),     32'(mr));
        check({tag, ".i_addr_ok"}, 32'(i_addr_ok), 32'(iao));
        check({tag, ".i_data_ok"}, 32'(i_data_ok), 32'(ido));
        check({tag, ".d_addr_ok"}, 32'(d_addr_ok), 32'(dao));
        check({tag, ".d_data_ok"}, 32'(d_data_ok), 32'(ddo));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_order [4];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
`else
        exp_order = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
`endif
        rst = 1'b0;
        i_req = 0; i_wr = 0; i_size = 2'b10; i_addr = '0; i_wdata = '0;
        d_req = 0; d_wr = 0; d_size = 2'b10; d_addr = '0; d_wdata = '0;
        m_rdata = '0; m_addr_ok = 0; m_data_ok = 0;

        // Reset state
        step(); step();
        #1 hs("rst", 0, 0, 0, 0, 0);
        check("rst.m_addr", m_addr, 32'h0);
        rst = 1'b1;

        // Single read from I
        step();
        i_req = 1; i_addr = 32'hBFC00000; i_size = 2'b10;
        #1 hs("t1.idle", 0, 0, 0, 0, 0);
        step();
        #1 hs("t1.addr0", 1, 0, 0, 0, 0);
        check("t1.m_addr", m_addr, 32'hBFC00000);
        check("t1.m_wr", 32'(m_wr), 32'h0);
        step();
        m_addr_ok = 1;
        #1 hs("t1.addr1", 1, 1, 0, 0, 0);
        step();
        m_addr_ok = 0; i_req = 0;
        #1 hs("t1.data0", 0, 0, 0, 0, 0);
        step();
        #1 hs("t1.data1", 0, 0, 0, 0, 0);
        step();
        m_data_ok = 1; m_rdata = 32'h3C080001;
        #1 hs("t1.data2", 0, 0, 1, 0, 0);
        check("t1.i_rdata", i_rdata, 32'h3C080001);
        step();
        m_data_ok = 0;
        #1 hs("t1.idle2", 0, 0, 0, 0, 0);

        // Simultaneous requests: D write first, then I
        i_req = 1; i_addr = 32'h00400000; i_wr = 0;
        d_req = 1; d_addr = 32'h80001000; d_wr = 1; d_wdata = 32'hDEADBEEF; d_size = 2'b10;
        step();
        #1 check("t2.d_addr", m_addr, 32'h80001000);
        check("t2.d_wr", 32'(m_wr), 32'h1);
        check("t2.d_wdata", m_wdata, 32'hDEADBEEF);
        check("t2.d_size", 32'(m_size), 32'h2);
        m_addr_ok = 1;
        #1 hs("t2.d_aok", 1, 0, 0, 1, 0);
        step();
        m_addr_ok = 0; d_req = 0; m_data_ok = 1;
        #1 hs("t2.d_dok", 0, 0, 0, 0, 1);
        step();
        m_data_ok = 0;
        #1 hs("t2.arb", 0, 0, 0, 0, 0);
        step();
        #1 hs("t2.i_addr", 1, 0, 0, 0, 0);
        check("t2.i_m_addr", m_addr, 32'h00400000);
        check("t2.i_wr", 32'(m_wr), 32'h0);
        m_addr_ok = 1;
        step();
        m_addr_ok = 0; i_req = 0; m_data_ok = 1;
        #1 hs("t2.i_dok", 0, 0, 1, 0, 0);
        step();
        m_data_ok = 0;

        // Continuous requests from both masters for four transactions
        i_req = 1; i_addr = 32'h1000; i_wr = 0;
        d_req = 1; d_addr = 32'h2000; d_wr = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            #1 check($sformatf("t3.order%0d", k), m_addr, exp_order[k]);
            m_addr_ok = 1;
            #1 check($sformatf("t3.aok%0d", k), 32'({d_addr_ok, i_addr_ok}),
                     (exp_order[k] == 32'h2000) ? 32'h2 : 32'h1);
            step();
            m_addr_ok = 0; m_data_ok = 1;
            #1 check($sformatf("t3.dok%0d", k), 32'({d_data_ok, i_data_ok}),
                     (exp_order[k] == 32'h2000) ? 32'h2 : 32'h1);
            step();
            m_data_ok = 0;
            if (k == 3) begin
                i_req = 0; d_req = 0;
            end
        end

        // Latched fields: D changes address while in ADDR
        d_req = 1; d_addr = 32'h80000000;
        step();
        #1 check("t4.addr0", m_addr, 32'h80000000);
        d_addr = 32'h80000040;
        #1 check("t4.addr1", m_addr, 32'h80000000);
        step();
        #1 check("t4.addr2", m_addr, 32'h80000000);
        m_addr_ok = 1;
        #1 check("t4.addr3", m_addr, 32'h80000000);
        step();
        m_addr_ok = 0; d_req = 0; m_data_ok = 1;
        step();
        m_data_ok = 0;

        // Stray handshakes
        m_data_ok = 1;
        #1 hs("t5.idle_dok", 0, 0, 0, 0, 0);
        step();
        m_data_ok = 0;
        #1 hs("t5.still_idle", 0, 0, 0, 0, 0);
        i_req = 1; i_addr = 32'h00000010;
        step();
        m_addr_ok = 1;
        step();
        i_req = 0;
        #1 hs("t5.data_aok", 0, 0, 0, 0, 0);
        step();
        #1 hs("t5.data_aok2", 0, 0, 0, 0, 0);
        m_data_ok = 1;
        #1 hs("t5.data_dok", 0, 0, 1, 0, 0);
        step();
        m_addr_ok = 0; m_data_ok = 0;
        #1 hs("t5.idle_end", 0, 0, 0, 0, 0);

        // Reset in DATA
        d_req = 1; d_addr = 32'h80002000;
        step();
        m_addr_ok = 1;
        step();
        m_addr_ok = 0; d_req = 0; m_data_ok = 1;
        #1 hs("t6.pre", 0, 0, 0, 0, 1);
        #1 rst = 1'b0;
        #1 hs("t6.async", 0, 0, 0, 0, 0);
        check("t6.m_addr_clr", m_addr, 32'h0);
        step();
        m_data_ok = 0;
        step();
        rst = 1'b1; i_req = 1; i_addr = 32'h00000200;
        #1 hs("t6.rel", 0, 0, 0, 0, 0);
        step();
        #1 hs("t6.grant", 1, 0, 0, 0, 0);
        check("t6.grant_addr", m_addr, 32'h00000200);
        m_addr_ok = 1;
        step();
        m_addr_ok = 0; i_req = 0; m_data_ok = 1;
        #1 hs("t6.dok", 0, 0, 1, 0, 0);
        step();
        m_data_ok = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares one SRAM-like memory port (toward the AXI bridge) between the instruction cache (master I) and the data cache (master D).
- Single outstanding transaction. The winner's request fields are latched at grant, and completion handshakes are routed back only to the owner.
- Sits between i_cache/d_cache and the SRAM-to-AXI converter.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- i_req, i_wr  in  1 each  I-master request / write flag
- i_size  in  2  I-master size (00 byte, 01 half, 10 word)
- i_addr  in  ADDR_WIDTH  I-master address
- i_wdata  in  DATA_WIDTH  I-master write data
- i_rdata  out  DATA_WIDTH  read data to I-master
- i_addr_ok, i_data_ok  out  1 each  address accepted / data returned, I-master
- d_req, d_wr, d_size, d_addr, d_wdata  in  same widths as I-master equivalents  D-master request fields
- d_rdata, d_addr_ok, d_data_ok  out  same widths as I-master equivalents  D-master returns
- m_req, m_wr  out  1 each  request / write to memory port
- m_size  out  2  size to memory port
- m_addr  out  ADDR_WIDTH  address to memory port
- m_wdata  out  DATA_WIDTH  write data to memory port
- m_rdata  in  DATA_WIDTH  read data from memory port
- m_addr_ok, m_data_ok  in  1 each  memory-port handshakes

Behaviour:
- FSM states: IDLE, ADDR, DATA, 2-bit encoding. Reset (rst=0, asynchronous) forces:
  - state=IDLE, owner=none
  - latched fields=0, last_grant=I
  - m_req=0, all *_addr_ok/*_data_ok=0
- IDLE:
  - If either i_req or d_req is 1 at a clk edge, pick the winner, set owner, latch the winner's wr/size/addr/wdata, and go to ADDR.
  - Otherwise remain in IDLE.
  - Arbitration cost: exactly 1 cycle; m_req is never asserted in IDLE.
- Default priority: D beats I on a simultaneous request.
- ADDR:
  - m_req=1; m_wr/m_size/m_addr/m_wdata are driven from the latched fields only.
  - Owner's addr_ok = m_addr_ok, combinationally, in the same cycle.
  - On an edge with m_addr_ok=1, go to DATA.
  - Masters keep req asserted until their addr_ok (SRAM-like rule); the arbiter does not depend on it after grant.
- DATA:
  - m_req=0.
  - Owner's data_ok = m_data_ok, combinationally; i_rdata = d_rdata = m_rdata at all times.
  - On an edge with m_data_ok=1, go to IDLE, clear owner, update last_grant.
- Non-owner addr_ok/data_ok are always 0.
- A m_data_ok arriving in IDLE or ADDR is ignored and is not forwarded to either master.
- A m_addr_ok arriving in IDLE or DATA is ignored.
- A new grant can start the cycle after data_ok, so back-to-back transactions take at least 3 cycles each (IDLE, ADDR, DATA).
- A request withdrawn after grant still completes on the memory port; the result is returned to the recorded owner.
- Reset asserted mid-transaction aborts immediately. After reset release the FSM restarts in IDLE with no memory of the aborted request.
- Sizes and addresses pass through unmodified; no alignment checks are performed.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous i_req and d_req in IDLE, the master not equal to last_grant wins. last_grant updates on completion; its reset value is I, so the first conflict goes to D.
- Undefined: fixed D-over-I priority and last_grant is not implemented.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Single read: i_req=1, i_addr=0xBFC00000, m_addr_ok after 2 cycles, m_data_ok with m_rdata=0x3C080001 after 3 more.
  - Required: m_req high only in ADDR.
  - Required: i_addr_ok and i_data_ok pulse 1 cycle each, i_rdata=0x3C080001.
  - Required: d_* handshakes stay 0 throughout.
- Simultaneous requests, fixed priority: i_req=d_req=1 held, d_addr=0x80001000 write, wdata=0xDEADBEEF, size=10.
  - Required: D is served first with m_wr=1 and m_addr=0x80001000.
  - Required: I is granted the cycle after d_data_ok.
- Round-robin (ARB_ROUND_ROBIN_EN defined): both masters request continuously for 4 transactions.
  - Required: grant order D, I, D, I.
  - Required: without the macro, the order is D, D, D, D.
- Latched fields: d_addr changes from 0x80000000 to 0x80000040 during ADDR.
  - Required: m_addr stays 0x80000000 until m_addr_ok.
- Stray handshakes: m_data_ok=1 pulsed in IDLE, and m_addr_ok=1 held during DATA.
  - Required: no addr_ok/data_ok to either master.
  - Required: no extra state transition.
- Reset mid-transaction: rst=0 asynchronously while in DATA.
  - Required: m_req=0 and all handshakes=0 immediately, before the next clk edge.
  - Required: after release with i_req=1, a fresh grant with 1-cycle arbitration latency.
